// File: rtl/riscv_i32_debug_injector.sv
// riscv_i32_debug_injector
// Turns debug-module GPR/CSR access requests into debug instructions issued to
// a halted core pipeline, waits for the pipeline to accept them (and, for
// reads, to return data), then presents a single response.
//
// Optional build macro: RISCV_DEBUG_INJECTOR_TIMEOUT_EN
//   When defined, an 8-bit watchdog bounds the time spent in ISSUE plus
//   WAIT_RESULT and converts a stuck operation into an error response.
//   When undefined, ISSUE and WAIT_RESULT wait indefinitely.
//
// state        | meaning
// -------------+---------------------------------------------------------
// IDLE         | ready for a request, dbg_req_ack asserted
// ISSUE        | debug instruction presented until pipe_accept
// WAIT_RESULT  | read accepted, waiting for result_valid
// RESPOND      | response held until dbg_resp_ready
module riscv_i32_debug_injector (
  input  logic        clk,
  input  logic        reset,
  input  logic        riscv_config__debug_enable,
  input  logic        halted,
  input  logic        dbg_req_valid,
  output logic        dbg_req_ack,
  input  logic        dbg_req_write,
  input  logic        dbg_req_gpr,
  input  logic [11:0] dbg_req_addr,
  input  logic [31:0] dbg_req_wdata,
  output logic [31:0] instruction__data,
  output logic        instruction__debug__valid,
  output logic [1:0]  instruction__debug__debug_op,
  output logic [15:0] instruction__debug__data,
  input  logic        pipe_accept,
  input  logic        result_valid,
  input  logic [31:0] result_data,
  output logic        dbg_resp_valid,
  input  logic        dbg_resp_ready,
  output logic [31:0] dbg_resp_data,
  output logic        dbg_resp_error,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_ISSUE       = 2'd1;
  localparam logic [1:0] ST_WAIT_RESULT = 2'd2;
  localparam logic [1:0] ST_RESPOND     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        req_write_q, req_write_d;
  logic        req_gpr_q, req_gpr_d;
  logic [11:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_error_q, resp_error_d;
  // Held low through reset and for the edge that releases it, so the ack
  // cannot appear while reset is still asserted.
  logic        ack_en_q;

  logic        capture;
  logic        req_legal;
  logic        timeout_hit;
  logic        issuing;
  logic        responding;

  assign dbg_req_ack = (state_q == ST_IDLE) && ack_en_q;
  assign capture     = dbg_req_valid && dbg_req_ack;

  // Only GPRs x0..x31 exist; any upper address bit set on a GPR access is illegal.
  assign req_legal = riscv_config__debug_enable && halted &&
                     !(dbg_req_gpr && (dbg_req_addr[11:5] != 7'd0));

`ifdef RISCV_DEBUG_INJECTOR_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  // Watchdog: restarts when a legal request enters ISSUE, counts while the
  // operation is outstanding in the pipeline.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (capture && req_legal) begin
      tmo_cnt_d = 8'd0;
    end else if ((state_q == ST_ISSUE) || (state_q == ST_WAIT_RESULT)) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  // Watchdog register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= 8'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign timeout_hit = (tmo_cnt_q == 8'hFF);
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and captured-data logic; pipeline handshakes take priority
  // over the watchdog in the same cycle.
  always_comb begin
    state_d      = state_q;
    req_write_d  = req_write_q;
    req_gpr_d    = req_gpr_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;

    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          req_write_d = dbg_req_write;
          req_gpr_d   = dbg_req_gpr;
          req_addr_d  = dbg_req_addr;
          req_wdata_d = dbg_req_wdata;
          if (req_legal) begin
            state_d = ST_ISSUE;
          end else begin
            state_d      = ST_RESPOND;
            resp_data_d  = 32'd0;
            resp_error_d = 1'b1;
          end
        end
      end

      ST_ISSUE: begin
        if (pipe_accept) begin
          if (req_write_q) begin
            state_d      = ST_RESPOND;
            resp_data_d  = 32'd0;
            resp_error_d = 1'b0;
          end else begin
            state_d = ST_WAIT_RESULT;
          end
        end else if (timeout_hit) begin
          state_d      = ST_RESPOND;
          resp_data_d  = 32'd0;
          resp_error_d = 1'b1;
        end
      end

      ST_WAIT_RESULT: begin
        if (result_valid) begin
          state_d      = ST_RESPOND;
          resp_data_d  = result_data;
          resp_error_d = 1'b0;
        end else if (timeout_hit) begin
          state_d      = ST_RESPOND;
          resp_data_d  = 32'd0;
          resp_error_d = 1'b1;
        end
      end

      ST_RESPOND: begin
        if (dbg_resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured request/response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_write_q  <= 1'b0;
      req_gpr_q    <= 1'b0;
      req_addr_q   <= 12'd0;
      req_wdata_q  <= 32'd0;
      resp_data_q  <= 32'd0;
      resp_error_q <= 1'b0;
      ack_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_write_q  <= req_write_d;
      req_gpr_q    <= req_gpr_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      ack_en_q     <= 1'b1;
    end
  end

  assign issuing    = (state_q == ST_ISSUE);
  assign responding = (state_q == ST_RESPOND);

  // Issue fields are forced to zero whenever no instruction is presented.
  assign instruction__debug__valid    = issuing;
  assign instruction__data            = issuing ? req_wdata_q : 32'd0;
  assign instruction__debug__debug_op = issuing ? {1'b0, req_write_q} : 2'b00;
  assign instruction__debug__data     = issuing ? {3'b000, req_gpr_q, req_addr_q} : 16'h0000;

  assign dbg_resp_valid = responding;
  assign dbg_resp_data  = responding ? resp_data_q : 32'd0;
  assign dbg_resp_error = responding ? resp_error_q : 1'b0;

  assign busy = (state_q != ST_IDLE);

endmodule
